// File: rtl/axis_packet_rr_arbiter_pkg.sv
// Shared constants for the packet round-robin arbiter: FSM encoding and the
// bit-width helper also used by the FIFO wrappers.
package axis_packet_rr_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Bits needed to hold any value in [0, value]; never less than 1.
  function automatic int num_bits(input int value);
    int bits;
    bits = 1;
    for (int b = 1; b < 32; b++) begin
      if ((value >> b) != 0) bits = b + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/axis_packet_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request found searching
// upward from last+1 with wrap-around.
module rr_priority_picker #(
  parameter int NumInputs  = 4,
  parameter int GrantWidth = 2
) (
  input  logic [NumInputs-1:0]  req,
  input  logic [GrantWidth-1:0] last,
  output logic                  valid,
  output logic [GrantWidth-1:0] idx
);

  int cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    // Offset NumInputs lands back on last itself, so it has lowest priority.
    for (int off = 1; off <= NumInputs; off++) begin
      cand = (int'(last) + off) % NumInputs;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand[GrantWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin merge of NumInputs AXI-Stream sources onto one
// registered AXI-Stream master; a grant is held from first beat through tlast.
module axis_packet_rr_arbiter
  import axis_packet_rr_arbiter_pkg::*;
#(
  parameter int  NumInputs  = 4,
  parameter int  TDataWidth = 32,
  parameter int  TidWidth   = 8,
  parameter int  TdestWidth = 8,
  localparam int GrantWidth = num_bits(NumInputs - 1)
) (
  input  logic                             aclk,
  input  logic                             arstn,
  input  logic [NumInputs*TidWidth-1:0]    s_axis_tid,
  input  logic [NumInputs*TdestWidth-1:0]  s_axis_tdest,
  input  logic [NumInputs*TDataWidth-1:0]  s_axis_tdata,
  input  logic [NumInputs-1:0]             s_axis_tvalid,
  input  logic [NumInputs-1:0]             s_axis_tlast,
  output logic [NumInputs-1:0]             s_axis_tready,
  output logic [TidWidth-1:0]              m_axis_tid,
  output logic [TdestWidth-1:0]            m_axis_tdest,
  output logic [TDataWidth-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [GrantWidth-1:0]            grant_idx,
  output logic                             busy
);

  arb_state_e            state, state_next;
  logic [GrantWidth-1:0] grant_next, last_grant, last_next;
  logic                  pick_valid;
  logic [GrantWidth-1:0] pick_idx;
  logic                  slot_free, accept;

  logic [TidWidth-1:0]   tid_arr   [NumInputs];
  logic [TdestWidth-1:0] tdest_arr [NumInputs];
  logic [TDataWidth-1:0] tdata_arr [NumInputs];

  for (genvar i = 0; i < NumInputs; i++) begin : g_slice
    assign tid_arr[i]   = s_axis_tid[i*TidWidth +: TidWidth];
    assign tdest_arr[i] = s_axis_tdest[i*TdestWidth +: TdestWidth];
    assign tdata_arr[i] = s_axis_tdata[i*TDataWidth +: TDataWidth];
  end

  rr_priority_picker #(
    .NumInputs (NumInputs),
    .GrantWidth(GrantWidth)
  ) u_picker (
    .req  (s_axis_tvalid),
    .last (last_grant),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  // Handshake: a beat moves on a port in any cycle where its valid and ready
  // are both high at the clock edge; valid never waits on ready, and only the
  // granted input's ready may rise, combinationally from m_axis_tready when
  // the output register is full.
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign accept    = s_axis_tvalid[grant_idx] && s_axis_tready[grant_idx];
  assign busy      = (state == LOCKED);

  always_comb begin
    s_axis_tready = '0;
    if (state == LOCKED) s_axis_tready[grant_idx] = slot_free;
  end

  always_comb begin
    state_next = state;
    grant_next = grant_idx;
    last_next  = last_grant;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = LOCKED;
          grant_next = pick_idx;
        end
      end
      LOCKED: begin
        if (accept && s_axis_tlast[grant_idx]) begin
          state_next = IDLE;
          last_next  = grant_idx;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= GrantWidth'(NumInputs - 1);
    end else begin
      state      <= state_next;
      grant_idx  <= grant_next;
      last_grant <= last_next;
    end
  end

  // Output register: reload on accept (even while draining), else clear on drain.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast[grant_idx];
      m_axis_tdata  <= tdata_arr[grant_idx];
      m_axis_tid    <= tid_arr[grant_idx];
      m_axis_tdest  <= tdest_arr[grant_idx];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed bench for axis_packet_rr_arbiter: per-input source queues, an
// expected-beat scoreboard, handshake invariants and a final report.
module tb_axis_packet_rr_arbiter;

  localparam int N  = 4;
  localparam int BW = 49; // {tid[8], tdest[8], tdata[32], tlast}

  logic          aclk = 1'b0;
  logic          arstn = 1'b1;
  logic [N*8-1:0]  s_axis_tid = '0;
  logic [N*8-1:0]  s_axis_tdest = '0;
  logic [N*32-1:0] s_axis_tdata = '0;
  logic [N-1:0]    s_axis_tvalid = '0;
  logic [N-1:0]    s_axis_tlast = '0;
  logic [N-1:0]    s_axis_tready;
  logic [7:0]      m_axis_tid;
  logic [7:0]      m_axis_tdest;
  logic [31:0]     m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready = 1'b1;
  logic [1:0]      grant_idx;
  logic            busy;

  axis_packet_rr_arbiter dut (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant_idx(grant_idx), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] src_q [N][$];
  logic          ready_pat [$];
  int            xfer_cyc [$];
  int            accepted [N];
  bit            mon_en = 1'b1;
  bit            stall_prev = 1'b0;
  logic [BW-1:0] held = '0;
  int            checks = 0;
  int            passes = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input int src, input logic [7:0] tid, input logic [7:0] tdest,
                          input logic [31:0] base, input int len);
    logic [BW-1:0] beat;
    for (int b = 0; b < len; b++) begin
      beat = {tid, tdest, base + 32'(b), (b == len - 1)};
      src_q[src].push_back(beat);
      exp_q.push_back(beat);
    end
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending() || m_axis_tvalid) && n < 300) begin
      @(posedge aclk); #2; n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_m_tlast"}, m_axis_tlast, 0);
    check({tag, "_m_tdata"}, m_axis_tdata, 0);
    check({tag, "_m_tid"}, m_axis_tid, 0);
    check({tag, "_m_tdest"}, m_axis_tdest, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant_idx, 0);
  endtask

  task automatic do_reset(input bit chk);
    arstn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    ready_pat.delete();
    exp_q.delete();
    #1;
    if (chk) reset_checks("reset");
    repeat (3) @(posedge aclk);
    #3 arstn = 1'b1;
  endtask

  task automatic expect_grant(input string tag, input logic [1:0] g);
    int n = 0;
    while (!busy && n < 50) begin @(posedge aclk); #2; n++; end
    check({tag, "_busy"}, busy, 1);
    check({tag, "_grant"}, grant_idx, g);
  endtask

  // ---------------- driver + monitor ----------------
  initial begin : drive_mon
    logic [BW-1:0] cur, head, exp_beat;
    logic [N-1:0]  took, mask;
    forever begin
      @(negedge aclk);
      cur  = {m_axis_tid, m_axis_tdest, m_axis_tdata, m_axis_tlast};
      mask = busy ? (4'b0001 << grant_idx) : 4'b0000;
      check("tready_only_granted", s_axis_tready & ~mask, 0);
      if (mon_en) begin
        if (stall_prev) check("stall_hold", cur, held);
        if (m_axis_tvalid && m_axis_tready) begin
          xfer_cyc.push_back(cyc);
          if (exp_q.size() == 0) check("unexpected_beat", m_axis_tvalid, 0);
          else begin
            exp_beat = exp_q.pop_front();
            check("out_beat", cur, exp_beat);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      if (stall_prev) begin
        held = cur;
        if (mon_en) check("stall_tready", s_axis_tready, 0);
      end
      took = s_axis_tvalid & s_axis_tready;
      @(posedge aclk); #1;
      for (int i = 0; i < N; i++) begin
        if (took[i] && src_q[i].size() != 0) begin
          void'(src_q[i].pop_front());
          accepted[i]++;
        end
      end
      m_axis_tready = (ready_pat.size() != 0) ? ready_pat.pop_front() : 1'b1;
      for (int i = 0; i < N; i++) begin
        head = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        s_axis_tvalid[i]        = (src_q[i].size() != 0);
        s_axis_tid[i*8 +: 8]    = head[48:41];
        s_axis_tdest[i*8 +: 8]  = head[40:33];
        s_axis_tdata[i*32 +: 32] = head[32:1];
        s_axis_tlast[i]         = head[0];
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    #1;
    do_reset(1'b1);

    // 1: single 3-beat packet on input 0
    send_pkt(0, 8'h01, 8'h05, 32'hA0, 3);
    expect_grant("t1", 2'd0);
    wait_drain("t1");

    // 2: all inputs busy with 2-beat packets, order 0,1,2,3,0
    do_reset(1'b0);
    xfer_cyc.delete();
    send_pkt(0, 8'h10, 8'h00, 32'h200, 2);
    send_pkt(1, 8'h11, 8'h01, 32'h210, 2);
    send_pkt(2, 8'h12, 8'h02, 32'h220, 2);
    send_pkt(3, 8'h13, 8'h03, 32'h230, 2);
    send_pkt(0, 8'h10, 8'h00, 32'h280, 2);
    wait_drain("t2");
    check("t2_beats", xfer_cyc.size(), 10);
    if (xfer_cyc.size() == 10) check("t2_span_cycles", xfer_cyc[9] - xfer_cyc[0], 13);

    // 3: input 1 requests in the middle of input 2's packet
    send_pkt(2, 8'h22, 8'h07, 32'h300, 4);
    accepted[2] = 0;
    n = 0;
    while (accepted[2] < 2 && n < 50) begin @(posedge aclk); #2; n++; end
    check("t3_mid_seen", accepted[2] >= 2, 1);
    send_pkt(1, 8'h21, 8'h06, 32'h310, 2);
    check("t3_grant_held", grant_idx, 2);
    wait_drain("t3");

    // 4: downstream stalls mid-packet
    send_pkt(0, 8'h04, 8'h04, 32'h10, 4);
    n = 0;
    while (!m_axis_tvalid && n < 50) begin @(posedge aclk); #2; n++; end
    check("t4_valid_seen", m_axis_tvalid, 1);
    ready_pat.push_back(1'b1);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b1);
    wait_drain("t4");

    // 5: single-beat packets on inputs 3 and 0 after reset, twice
    do_reset(1'b0);
    send_pkt(0, 8'h30, 8'h00, 32'h500, 1);
    send_pkt(3, 8'h33, 8'h03, 32'h503, 1);
    wait_drain("t5a");
    check("t5_last_grant", grant_idx, 3);
    send_pkt(0, 8'h30, 8'h00, 32'h510, 1);
    send_pkt(3, 8'h33, 8'h03, 32'h513, 1);
    wait_drain("t5b");

    // 6: reset pulse during beat 2 of a 4-beat packet
    mon_en = 1'b0;
    accepted[0] = 0;
    for (int b = 0; b < 4; b++) src_q[0].push_back({8'h60, 8'h06, 32'h600 + 32'(b), b == 3});
    n = 0;
    while (accepted[0] < 2 && n < 50) begin @(posedge aclk); #2; n++; end
    check("t6_beat2_seen", accepted[0] >= 2, 1);
    check("t6_pre_valid", m_axis_tvalid, 1);
    arstn = 1'b0;
    #1;
    reset_checks("t6_async");
    do_reset(1'b0);
    stall_prev = 1'b0;
    mon_en = 1'b1;
    send_pkt(0, 8'h70, 8'h00, 32'h700, 2);
    send_pkt(2, 8'h72, 8'h02, 32'h720, 2);
    expect_grant("t6_post", 2'd0);
    wait_drain("t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
